// File: rtl/emu_ckpt_pkg.sv
// Shared constants for the emulation checkpoint wrapper: address width helper,
// FF chain field offsets and sizes, LFSR polynomial and RAM scan direction.
package emu_ckpt_pkg;

  localparam logic [31:0]  LFSR_POLY = 32'h0040_0007;
  localparam int unsigned  CNT_OFS   = 0;
  localparam int unsigned  LFSR_OFS  = 32;
  localparam int unsigned  WEN_OFS   = 64;
  localparam int unsigned  WADDR_OFS = 65;

  typedef enum logic {
    RAM_DIR_READ  = 1'b0,
    RAM_DIR_WRITE = 1'b1
  } ram_dir_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned wdata_ofs(input int unsigned depth);
    return WADDR_OFS + addr_width(depth);
  endfunction

  function automatic int unsigned ff_bit_count(input int unsigned depth, input int unsigned width);
    return wdata_ofs(depth) + width;
  endfunction

  function automatic int unsigned ram_bit_count(input int unsigned depth, input int unsigned width);
    return depth * width;
  endfunction

endpackage

// File: rtl/emu_ram_scan_ctrl.sv
// Serial dump/load of the user memory: word pointer, prefetching read buffer,
// write shift buffer and a hold register committed one edge after completion.
module emu_ram_scan_ctrl
  import emu_ckpt_pkg::*;
#(
  parameter  int unsigned MEM_DEPTH  = 16,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned AW         = addr_width(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  sr,
  input  logic                  se,
  input  logic                  sd,
  input  logic                  di,
  output logic                  dout,
  output logic [AW-1:0]         raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  commit,
  output logic [AW-1:0]         commit_addr,
  output logic [DATA_WIDTH-1:0] commit_data
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);

  logic [AW-1:0]         ptr;
  logic [BW-1:0]         bit_cnt;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_buf;
  logic [DATA_WIDTH-1:0] wr_buf;
  logic [DATA_WIDTH-1:0] wr_next;
  logic                  hold_valid;
  logic [AW-1:0]         hold_addr;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  last_bit;
  ram_dir_e              dir;

  assign dir         = ram_dir_e'(sd);
  assign last_bit    = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign wr_next     = {di, wr_buf[DATA_WIDTH-1:1]};
  assign raddr       = ptr;
  assign dout        = rd_buf[0];
  assign commit      = en && hold_valid;
  assign commit_addr = hold_addr;
  assign commit_data = hold_data;

  // No reset: the pointer must survive user reset, and SR initialises it.
  // The async read of mem[ptr] is the prefetch, so word boundaries need no gap.
  always_ff @(posedge clk) begin
    if (en) begin
      if (hold_valid) hold_valid <= 1'b0;
      if (sr) begin
        ptr      <= '0;
        bit_cnt  <= '0;
        rd_valid <= 1'b0;
      end else if (dir == RAM_DIR_READ) begin
        if (!rd_valid) begin
          rd_buf   <= rdata;
          rd_valid <= 1'b1;
          ptr      <= ptr + AW'(1);
        end else if (se) begin
          if (last_bit) begin
            rd_buf  <= rdata;
            ptr     <= ptr + AW'(1);
            bit_cnt <= '0;
          end else begin
            rd_buf  <= rd_buf >> 1;
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
      end else if (se) begin
        wr_buf <= wr_next;
        if (last_bit) begin
          hold_data  <= wr_next;
          hold_addr  <= ptr;
          hold_valid <= 1'b1;
          ptr        <= ptr + AW'(1);
          bit_cnt    <= '0;
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/emu_ckpt_system.sv
// Emulation wrapper: toy trace core with FF-chain and RAM scan checkpointing.
// Define EMU_TRACE_EN to expose the trace_* ports.
module emu_ckpt_system
  import emu_ckpt_pkg::*;
#(
  parameter  int unsigned MEM_DEPTH  = 16,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned AW         = addr_width(MEM_DEPTH)
) (
  input  logic EMU_HOST_CLK,
  input  logic EMU_PORT_reset_imp_user_rst,
  input  logic EMU_RUN_MODE,
  input  logic EMU_SCAN_MODE,
  input  logic EMU_FF_SE,
  input  logic EMU_FF_DI,
  output logic EMU_FF_DO,
  input  logic EMU_RAM_SR,
  input  logic EMU_RAM_SE,
  input  logic EMU_RAM_SD,
  input  logic EMU_RAM_DI,
  output logic EMU_RAM_DO
`ifdef EMU_TRACE_EN
  ,
  output logic                  trace_wen,
  output logic [AW-1:0]         trace_waddr,
  output logic [DATA_WIDTH-1:0] trace_wdata
`endif
);

  localparam int unsigned N         = ff_bit_count(MEM_DEPTH, DATA_WIDTH);
  localparam int unsigned WDATA_OFS = wdata_ofs(MEM_DEPTH);

  logic                  clk;
  logic                  rst;
  logic [31:0]           cnt;
  logic [31:0]           lfsr;
  logic                  trace_wen_q;
  logic [AW-1:0]         trace_waddr_q;
  logic [DATA_WIDTH-1:0] trace_wdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [N-1:0]          chain;
  logic [N-1:0]          chain_shifted;
  logic                  scan_en;
  logic [AW-1:0]         run_addr;
  logic [DATA_WIDTH-1:0] run_word;
  logic [AW-1:0]         ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  commit;
  logic [AW-1:0]         commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;

  assign clk           = EMU_HOST_CLK;
  assign rst           = EMU_PORT_reset_imp_user_rst;
  assign scan_en       = !EMU_RUN_MODE && EMU_SCAN_MODE;
  assign chain         = {trace_wdata_q, trace_waddr_q, trace_wen_q, lfsr, cnt};
  assign chain_shifted = {EMU_FF_DI, chain[N-1:1]};
  assign EMU_FF_DO     = chain[0];
  assign run_addr      = cnt[AW-1:0];
  assign run_word      = mem[run_addr] ^ lfsr;
  assign ram_rdata     = mem[ram_raddr];

`ifdef EMU_TRACE_EN
  assign trace_wen   = trace_wen_q;
  assign trace_waddr = trace_waddr_q;
  assign trace_wdata = trace_wdata_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      lfsr          <= 32'h0000_0001;
      trace_wen_q   <= 1'b0;
      trace_waddr_q <= '0;
      trace_wdata_q <= '0;
    end else if (EMU_RUN_MODE) begin
      cnt           <= cnt + 32'd1;
      lfsr          <= {lfsr[30:0], 1'b0} ^ (lfsr[31] ? LFSR_POLY : '0);
      trace_wen_q   <= 1'b1;
      trace_waddr_q <= run_addr;
      trace_wdata_q <= run_word;
    end else if (scan_en && EMU_FF_SE) begin
      cnt           <= chain_shifted[CNT_OFS +: 32];
      lfsr          <= chain_shifted[LFSR_OFS +: 32];
      trace_wen_q   <= chain_shifted[WEN_OFS];
      trace_waddr_q <= chain_shifted[WADDR_OFS +: AW];
      trace_wdata_q <= chain_shifted[WDATA_OFS +: DATA_WIDTH];
    end
  end

  // Memory holds during user reset so a held reset cannot disturb the image.
  always_ff @(posedge clk) begin
    if (EMU_RUN_MODE && !rst) mem[run_addr] <= run_word;
    else if (commit)          mem[commit_addr] <= commit_data;
  end

  emu_ram_scan_ctrl #(
    .MEM_DEPTH  (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram_scan (
    .clk         (clk),
    .en          (scan_en),
    .sr          (EMU_RAM_SR),
    .se          (EMU_RAM_SE),
    .sd          (EMU_RAM_SD),
    .di          (EMU_RAM_DI),
    .dout        (EMU_RAM_DO),
    .raddr       (ram_raddr),
    .rdata       (ram_rdata),
    .commit      (commit),
    .commit_addr (commit_addr),
    .commit_data (commit_data)
  );

endmodule

// File: tb/tb_emu_ckpt_system.sv
// Bench for emu_ckpt_system: behavioural core/memory model, per-cycle FF_DO
// (and trace port, with EMU_TRACE_EN) comparison, plus full scan dump checks.
module tb_emu_ckpt_system;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int N     = 97 + AW;
  localparam int RB    = DEPTH * DW;

  logic clk = 1'b0, rst = 1'b1, run = 1'b0, scan = 1'b0;
  logic ff_se = 1'b0, ff_di = 1'b0, ram_sr = 1'b0, ram_se = 1'b0, ram_sd = 1'b0, ram_di = 1'b0;
  logic ff_do, ram_do;
`ifdef EMU_TRACE_EN
  logic          t_wen;
  logic [AW-1:0] t_waddr;
  logic [DW-1:0] t_wdata;
`endif

  int tests = 0;
  int fails = 0;
  logic chk = 1'b0;

  emu_ckpt_system #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .EMU_HOST_CLK                (clk),
    .EMU_PORT_reset_imp_user_rst (rst),
    .EMU_RUN_MODE                (run),
    .EMU_SCAN_MODE               (scan),
    .EMU_FF_SE                   (ff_se),
    .EMU_FF_DI                   (ff_di),
    .EMU_FF_DO                   (ff_do),
    .EMU_RAM_SR                  (ram_sr),
    .EMU_RAM_SE                  (ram_se),
    .EMU_RAM_SD                  (ram_sd),
    .EMU_RAM_DI                  (ram_di),
    .EMU_RAM_DO                  (ram_do)
`ifdef EMU_TRACE_EN
    ,
    .trace_wen                   (t_wen),
    .trace_waddr                 (t_waddr),
    .trace_wdata                 (t_wdata)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0]   m_cnt, m_lfsr;
  logic          m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_wword;
  int            m_wbits = 0;
  int            m_wptr  = 0;

  function automatic logic [N-1:0] m_chain();
    return {m_wdata, m_waddr, m_wen, m_lfsr, m_cnt};
  endfunction

  function automatic logic [RB-1:0] m_ram();
    logic [RB-1:0] r;
    for (int w = 0; w < DEPTH; w++) r[w*DW +: DW] = m_mem[w];
    return r;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    logic [31:0] y;
    y = x << 1;
    if (x[31]) y = y ^ 32'h0040_0007;
    return y;
  endfunction

  always @(posedge clk or posedge rst) begin : model_ff
    logic [N-1:0] c;
    int a;
    if (rst) begin
      m_cnt = 0; m_lfsr = 32'd1; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
    end else if (run) begin
      a = int'(m_cnt % DEPTH);
      m_wdata  = m_mem[a] ^ m_lfsr;
      m_mem[a] = m_wdata;
      m_waddr  = AW'(a);
      m_wen    = 1'b1;
      m_cnt    = m_cnt + 1;
      m_lfsr   = lfsr_next(m_lfsr);
    end else if (scan && ff_se) begin
      c = m_chain();
      c = {ff_di, c[N-1:1]};
      {m_wdata, m_waddr, m_wen, m_lfsr, m_cnt} = c;
    end
  end

  always @(posedge clk) begin : model_ram
    if (!run && scan) begin
      if (ram_sr) begin
        m_wbits = 0; m_wptr = 0;
      end else if (ram_sd && ram_se) begin
        m_wword[m_wbits] = ram_di;
        m_wbits++;
        if (m_wbits == DW) begin
          m_mem[m_wptr] = m_wword;
          m_wptr  = (m_wptr + 1) % DEPTH;
          m_wbits = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [N-1:0] c;
    if (chk) begin
      c = m_chain();
      tests++;
      if (ff_do !== c[0]) begin
        fails++;
        $display("FAIL ff_do t=%0t got %b expected %b", $time, ff_do, c[0]);
      end
`ifdef EMU_TRACE_EN
      tests++;
      if ({t_wen, t_waddr, t_wdata} !== {m_wen, m_waddr, m_wdata}) begin
        fails++;
        $display("FAIL trace t=%0t got %b/%0h/%0h expected %b/%0h/%0h",
                 $time, t_wen, t_waddr, t_wdata, m_wen, m_waddr, m_wdata);
      end
`endif
    end
  end

  task automatic check(input string name, input logic [RB-1:0] got, input logic [RB-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- stimulus tasks (drive on negedge) ----------------
  task automatic run_cycles(input int n);
    @(negedge clk); scan = 1'b0; run = 1'b1;
    repeat (n) @(negedge clk);
    run = 1'b0;
  endtask

  task automatic ff_dump(output logic [N-1:0] img);
    int k = 0;
    img = '0;
    @(negedge clk); run = 1'b0; scan = 1'b1;
    while (k < N) begin
      @(negedge clk);
      ff_di = ff_do;
      ff_se = ($urandom_range(0, 3) != 0);
      if (ff_se) begin img[k] = ff_do; k++; end
    end
    @(negedge clk); ff_se = 1'b0;
  endtask

  task automatic ff_load(input logic [N-1:0] img);
    int k = 0;
    @(negedge clk); run = 1'b0; scan = 1'b1;
    while (k < N) begin
      @(negedge clk);
      ff_se = ($urandom_range(0, 3) != 0);
      if (ff_se) begin ff_di = img[k]; k++; end
    end
    @(negedge clk); ff_se = 1'b0;
  endtask

  task automatic ram_dump(output logic [RB-1:0] img);
    int k = 0;
    img = '0;
    @(negedge clk); run = 1'b0; scan = 1'b1; ram_sd = 1'b0; ram_sr = 1'b1; ram_se = 1'b0;
    @(negedge clk); ram_sr = 1'b0; ram_se = 1'b1;  // buffer still invalid: SE ignored
    @(negedge clk); ram_se = 1'b0;
    while (k < RB) begin
      @(negedge clk);
      ram_se = ($urandom_range(0, 3) != 0);
      if (ram_se) begin img[k] = ram_do; k++; end
    end
    @(negedge clk); ram_se = 1'b0;
  endtask

  task automatic ram_load(input logic [RB-1:0] img);
    int k = 0;
    @(negedge clk); run = 1'b0; scan = 1'b1; ram_sd = 1'b1; ram_sr = 1'b1; ram_se = 1'b0;
    @(negedge clk); ram_sr = 1'b0;
    while (k < RB) begin
      @(negedge clk);
      ram_se = ($urandom_range(0, 3) != 0);
      if (ram_se) begin ram_di = img[k]; k++; end
    end
    @(negedge clk); ram_se = 1'b1; ram_di = 1'($urandom);  // trailing partial bit
    @(negedge clk); ram_se = 1'b0; ram_sd = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [N-1:0]  img, img4, m4_chain, m40_chain;
  logic [RB-1:0] rimg, r4, m40_ram;

  initial begin
    for (int w = 0; w < DEPTH; w++) m_mem[w] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; chk = 1'b1;

    ff_dump(img);
    check("reset_cnt",   img[31:0],  32'd0);
    check("reset_lfsr",  img[63:32], 32'd1);
    check("reset_chain", img, m_chain());

    // Test 1: four run steps
    run_cycles(4);
    check("model_cnt4",  m_cnt,  32'd4);
    check("model_lfsr4", m_lfsr, 32'd16);

    // Test 2: non-destructive FF dump
    ff_dump(img4);
    check("ff4_cnt",   img4[31:0],  32'd4);
    check("ff4_lfsr",  img4[63:32], 32'd16);
    check("ff4_wen",   img4[64],    1'b1);
    check("ff4_waddr", img4[68:65], 4'd3);
    check("ff4_wdata", img4[100:69], 32'd8);
    check("ff4_model", img4, m_chain());
    m4_chain = m_chain();
    ff_dump(img);
    check("ff4_unchanged", img, m4_chain);

    // Test 3: RAM dump
    ram_dump(r4);
    check("ram4_w0", r4[31:0],   32'd1);
    check("ram4_w1", r4[63:32],  32'd2);
    check("ram4_w2", r4[95:64],  32'd4);
    check("ram4_w3", r4[127:96], 32'd8);
    check("ram4_rest", r4[RB-1:128], '0);
    ram_dump(rimg);
    check("ram4_unchanged", rimg, m_ram());

    // Test 4: run on, reload the cycle-4 images, resume
    run_cycles(36);
    m40_chain = m_chain();
    m40_ram   = m_ram();
    check("model_cnt40", m_cnt, 32'd40);
    ff_load(img4);
    ram_load(r4);
    ff_dump(img);
    check("reload_ff", img, m4_chain);
    run_cycles(36);
    ff_dump(img);
    check("resume_ff40", img, m40_chain);
    ram_dump(rimg);
    check("resume_ram40", rimg, m40_ram);

    // Test 5: scan inputs toggling while running
    @(negedge clk); scan = 1'b1; run = 1'b1;
    repeat (20) begin
      @(negedge clk);
      ff_se  = 1'($urandom); ff_di  = 1'($urandom);
      ram_se = 1'($urandom); ram_di = 1'($urandom);
      ram_sr = 1'($urandom); ram_sd = 1'($urandom);
    end
    run = 1'b0; ff_se = 1'b0; ram_se = 1'b0; ram_sr = 1'b0; ram_sd = 1'b0;
    check("model_cnt60", m_cnt, 32'd60);
    ff_dump(img);
    check("run_ignores_scan_ff", img, m_chain());
    ram_dump(rimg);
    check("run_ignores_scan_ram", rimg, m_ram());

    // Test 6: reset mid FF scan; RAM scan keeps working under reset
    @(negedge clk); scan = 1'b1;
    repeat (10) begin
      @(negedge clk); ff_se = 1'b1; ff_di = 1'($urandom);
    end
    #2 rst = 1'b1;
    #1 check("rst_ff_do", ff_do, 1'b0);
    repeat (5) begin
      @(negedge clk); ff_se = 1'b1; ff_di = 1'b1;
    end
    ff_se = 1'b0;
    ram_dump(rimg);
    check("ram_during_rst", rimg, m_ram());
    @(negedge clk); rst = 1'b0;
    ff_dump(img);
    check("post_rst_cnt",  img[31:0],  32'd0);
    check("post_rst_lfsr", img[63:32], 32'd1);
    check("post_rst_chain", img, m_chain());

    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
